// File: rtl/gray_conv_arbiter.sv
// Two-requester round-robin front end sharing one binary/gray converter and a
// single output register slot (EMPTY/FULL) that can drain and refill in one cycle.
module gray_conv_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_dir,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_id,
  output logic             out_dir,
  output logic             dbg_state
);

  // Handshake: a request transfers on a cycle where reqN_valid && reqN_ready;
  // the result transfers where out_valid && out_ready. ready never looks at data.
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]       state;
  logic             last_grant;
  logic             slot_free;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic [WIDTH-1:0] sel_data;
  logic             sel_dir;
  logic             sel_id;
  logic [WIDTH-1:0] conv;
  logic             acc;

  always_comb begin
    slot_free  = (state == EMPTY) || out_ready;
    // On a tie the requester that did not win last time gets the slot.
    grant0     = req0_valid && (!req1_valid || last_grant);
    grant1     = req1_valid && (!req0_valid || !last_grant);
    req0_ready = rst_n && slot_free && grant0;
    req1_ready = rst_n && slot_free && grant1;
    accept     = req0_ready || req1_ready;
    sel_id     = req1_ready;
    sel_data   = req1_ready ? req1_data : req0_data;
    sel_dir    = req1_ready ? req1_dir  : req0_dir;
  end

  always_comb begin
    conv = '0;
    acc  = 1'b0;
    if (!sel_dir) begin
      conv = sel_data ^ (sel_data >> 1);
    end else begin
      // Gray to binary is a running XOR from the MSB downwards.
      for (int i = WIDTH - 1; i >= 0; i--) begin
        acc     = acc ^ sel_data[i];
        conv[i] = acc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      last_grant <= 1'b1;
      out_data   <= '0;
      out_id     <= 1'b0;
      out_dir    <= 1'b0;
    end else if (accept) begin
      state      <= FULL;
      last_grant <= sel_id;
      out_data   <= conv;
      out_id     <= sel_id;
      out_dir    <= sel_dir;
    end else if ((state == FULL) && out_ready) begin
      state <= EMPTY;
    end
  end

  assign out_valid = (state == FULL);
  assign dbg_state = state[0];

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Bench for gray_conv_arbiter: a cycle model predicts grants and results,
// results are queued on acceptance and compared while they sit in the slot.
module tb_gray_conv_arbiter;

  localparam int WIDTH = 4;
  localparam int W     = WIDTH + 2;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req0_ready, req0_dir;
  logic             req1_valid, req1_ready, req1_dir;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic             out_valid, out_ready, out_id, out_dir, dbg_state;
  logic [WIDTH-1:0] out_data;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic         m_full;
  logic         m_last;
  logic         e_r0, e_r1, obs_r0, obs_r1;

  gray_conv_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_dir(req0_dir),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_dir(req1_dir),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .out_dir(out_dir), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] model_conv(input logic [WIDTH-1:0] d, input logic dir);
    logic [WIDTH-1:0] r;
    r = '0;
    if (!dir) r = d ^ (d >> 1);
    else for (int k = 0; k < WIDTH; k++) r = r ^ (d >> k);
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
    m_full = 1'b0; m_last = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one cycle, records the pre-edge ready values and advances the model.
  task automatic drive_cycle(input logic v0, input logic [WIDTH-1:0] d0, input logic dir0,
                             input logic v1, input logic [WIDTH-1:0] d1, input logic dir1,
                             input logic ordy);
    logic free;
    @(negedge clk);
    req0_valid = v0; req0_data = d0; req0_dir = dir0;
    req1_valid = v1; req1_data = d1; req1_dir = dir1;
    out_ready  = ordy;
    #1;
    obs_r0 = req0_ready;
    obs_r1 = req1_ready;
    free = !m_full || ordy;
    e_r0 = free && v0 && (!v1 || m_last);
    e_r1 = free && v1 && (!v0 || !m_last);
    if (m_full && ordy && exp_q.size() > 0) void'(exp_q.pop_front());
    if (e_r0) exp_q.push_back({1'b0, dir0, model_conv(d0, dir0)});
    else if (e_r1) exp_q.push_back({1'b1, dir1, model_conv(d1, dir1)});
    @(posedge clk);
    #1;
    if (e_r0 || e_r1) begin
      m_full = 1'b1;
      m_last = e_r1;
    end else if (ordy) begin
      m_full = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_data = 4'hF; req0_dir = 1'b1;
    req1_valid = 1'b1; req1_data = 4'hA; req1_dir = 1'b0;
    out_ready = 1'b1;
    m_full = 1'b0; m_last = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++;
      $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready); end
    checks++; if (out_valid !== 1'b0 || dbg_state !== 1'b0) begin errors++;
      $display("FAIL reset_valid: got valid=%b state=%b expected 0/0", out_valid, dbg_state); end
    checks++; if ({out_id, out_dir, out_data} !== '0) begin errors++;
      $display("FAIL reset_out: got id=%b dir=%b data=%h expected 0", out_id, out_dir, out_data); end
    do_reset();
  endtask

  task automatic test_convert_basic();
    drive_cycle(1'b1, 4'b0111, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    checks++; if (obs_r0 !== 1'b1 || obs_r1 !== 1'b0) begin errors++;
      $display("FAIL basic_ready0: got %b%b expected 10", obs_r0, obs_r1); end
    checks++; if (out_valid !== 1'b1 || {out_id, out_dir, out_data} !== {2'b00, 4'b0100}) begin errors++;
      $display("FAIL basic_b2g: got v=%b id=%b dir=%b data=%b expected 1/0/0/0100", out_valid, out_id, out_dir, out_data); end
    drive_cycle(1'b0, 4'h0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b1);
    checks++; if (obs_r1 !== 1'b1 || obs_r0 !== 1'b0) begin errors++;
      $display("FAIL basic_ready1: got %b%b expected 01", obs_r0, obs_r1); end
    checks++; if (out_valid !== 1'b1 || {out_id, out_dir, out_data} !== {2'b11, 4'b1010}) begin errors++;
      $display("FAIL basic_g2b: got v=%b id=%b dir=%b data=%b expected 1/1/1/1010", out_valid, out_id, out_dir, out_data); end
    drive_cycle(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0 || dbg_state !== 1'b0) begin errors++;
      $display("FAIL basic_drain: got valid=%b state=%b expected 0/0", out_valid, dbg_state); end
    // out_ready while EMPTY must not change anything.
    drive_cycle(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL basic_empty_ready: got valid=%b expected 0", out_valid); end
  endtask

  task automatic test_sweep();
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] v4;
    for (int v = 0; v < 16; v++) begin
      v4 = v[WIDTH-1:0];
      drive_cycle(1'b1, v4, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
      checks++; if (!out_valid || exp_q.size() == 0 || {out_id, out_dir, out_data} !== exp_q[0]) begin errors++;
        $display("FAIL sweep_b2g: in=%h got v=%b %b%b%h", v4, out_valid, out_id, out_dir, out_data); end
      g = out_data;
      drive_cycle(1'b0, 4'h0, 1'b0, 1'b1, g, 1'b1, 1'b1);
      checks++; if (!out_valid || out_data !== v4 || out_id !== 1'b1 || out_dir !== 1'b1) begin errors++;
        $display("FAIL sweep_roundtrip: in=%h got v=%b data=%h id=%b dir=%b", v4, out_valid, out_data, out_id, out_dir); end
    end
    drive_cycle(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] a, b;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      a = WIDTH'($urandom_range(0, 15));
      b = WIDTH'($urandom_range(0, 15));
      drive_cycle(1'b1, a, i[1], 1'b1, b, i[2], 1'b1);
      checks++; if (obs_r0 !== !i[0] || obs_r1 !== i[0] || obs_r0 !== e_r0 || obs_r1 !== e_r1) begin errors++;
        $display("FAIL b2b_grant: cycle %0d got %b%b expected %b%b", i, obs_r0, obs_r1, !i[0], i[0]); end
      checks++; if (!out_valid || out_id !== i[0] || exp_q.size() == 0 || {out_id, out_dir, out_data} !== exp_q[0]) begin errors++;
        $display("FAIL b2b_out: cycle %0d got v=%b %b%b%h", i, out_valid, out_id, out_dir, out_data); end
    end
    drive_cycle(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic test_hold();
    logic v0p, v1p;
    drive_cycle(1'b1, 4'h5, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 4'h9, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0);
      checks++; if (obs_r0 !== 1'b0 || obs_r1 !== 1'b0) begin errors++;
        $display("FAIL hold_ready: cycle %0d got %b%b expected 00", i, obs_r0, obs_r1); end
      checks++; if (!out_valid || {out_id, out_dir, out_data} !== {2'b00, 4'b0111}) begin errors++;
        $display("FAIL hold_stable: cycle %0d got v=%b %b%b%b expected 1 000111", i, out_valid, out_id, out_dir, out_data); end
    end
    v0p = 1'b1; v1p = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(v0p, 4'h9, 1'b1, v1p, 4'h3, 1'b0, 1'b1);
      checks++; if (obs_r0 !== e_r0 || obs_r1 !== e_r1) begin errors++;
        $display("FAIL hold_drain_grant: cycle %0d got %b%b expected %b%b", i, obs_r0, obs_r1, e_r0, e_r1); end
      checks++; if (out_valid !== m_full || (m_full && (exp_q.size() == 0 || {out_id, out_dir, out_data} !== exp_q[0]))) begin errors++;
        $display("FAIL hold_drain_out: cycle %0d got v=%b %b%b%h", i, out_valid, out_id, out_dir, out_data); end
      if (e_r0) v0p = 1'b0;
      if (e_r1) v1p = 1'b0;
    end
    checks++; if (v0p !== 1'b0 || v1p !== 1'b0) begin errors++;
      $display("FAIL hold_lost: pending %b%b expected 00", v0p, v1p); end
  endtask

  task automatic test_reset_mid();
    drive_cycle(1'b1, 4'h6, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    checks++; if (!out_valid || out_id !== 1'b0) begin errors++;
      $display("FAIL rmid_fill: got v=%b id=%b expected 1/0", out_valid, out_id); end
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || dbg_state !== 1'b0 || out_data !== '0) begin errors++;
      $display("FAIL rmid_async: got valid=%b state=%b data=%h expected 0/0/0", out_valid, dbg_state, out_data); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++;
      $display("FAIL rmid_ready: got %b%b expected 00", req0_ready, req1_ready); end
    m_full = 1'b0; m_last = 1'b1;
    exp_q.delete();
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    drive_cycle(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL rmid_no_emit: got valid=%b expected 0", out_valid); end
    drive_cycle(1'b1, 4'hC, 1'b0, 1'b1, 4'h2, 1'b1, 1'b1);
    checks++; if (obs_r0 !== 1'b1 || obs_r1 !== 1'b0) begin errors++;
      $display("FAIL rmid_tie: got %b%b expected 10", obs_r0, obs_r1); end
    checks++; if (!out_valid || {out_id, out_dir, out_data} !== {2'b00, 4'b1010}) begin errors++;
      $display("FAIL rmid_out: got v=%b %b%b%b expected 1 001010", out_valid, out_id, out_dir, out_data); end
    drive_cycle(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_convert_basic();
    test_sweep();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
